// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchroniser, 16x oversampled start/data/stop FSM.
// Optional even-parity stage and parity_err port enabled by `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity over data plus parity bit; a nonzero result is an error.
  function automatic logic even_parity_err(input logic [DBIT-1:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  state_t          state_r, state_nxt_s;
  logic            rx_meta_r, rx_sync_r;
  logic [4:0]      s_cnt_r, s_cnt_nxt_s;
  logic [2:0]      n_cnt_r, n_cnt_nxt_s;
  logic [DBIT-1:0] b_shift_r, b_shift_nxt_s;
  logic            par_bit_r, par_bit_nxt_s;
  logic            done_set_s;
  logic [DBIT-1:0] dout_r;
  logic            done_r, frame_err_r, parity_err_r;

  // Two-flop synchroniser; idles high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      s_cnt_r   <= 5'd0;
      n_cnt_r   <= 3'd0;
      b_shift_r <= '0;
      par_bit_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      s_cnt_r   <= s_cnt_nxt_s;
      n_cnt_r   <= n_cnt_nxt_s;
      b_shift_r <= b_shift_nxt_s;
      par_bit_r <= par_bit_nxt_s;
    end
  end

  // Next-state logic; idle->start ignores s_tick so counting starts on the next tick.
  always_comb begin
    state_nxt_s   = state_r;
    s_cnt_nxt_s   = s_cnt_r;
    n_cnt_nxt_s   = n_cnt_r;
    b_shift_nxt_s = b_shift_r;
    par_bit_nxt_s = par_bit_r;
    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_nxt_s = ST_START;
          s_cnt_nxt_s = 5'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_cnt_r == 5'd7) begin
            if (!rx_sync_r) begin
              state_nxt_s = ST_DATA;
              s_cnt_nxt_s = 5'd0;
              n_cnt_nxt_s = 3'd0;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            s_cnt_nxt_s = s_cnt_r + 5'd1;
          end
        end else begin
          s_cnt_nxt_s = s_cnt_r;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_cnt_r == 5'd15) begin
            b_shift_nxt_s = {rx_sync_r, b_shift_r[DBIT-1:1]};
            s_cnt_nxt_s   = 5'd0;
            if (n_cnt_r == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_nxt_s = ST_PARITY;
`else
              state_nxt_s = ST_STOP;
`endif
            end else begin
              n_cnt_nxt_s = n_cnt_r + 3'd1;
            end
          end else begin
            s_cnt_nxt_s = s_cnt_r + 5'd1;
          end
        end else begin
          s_cnt_nxt_s = s_cnt_r;
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_cnt_r == 5'd15) begin
            par_bit_nxt_s = rx_sync_r;
            s_cnt_nxt_s   = 5'd0;
            state_nxt_s   = ST_STOP;
          end else begin
            s_cnt_nxt_s = s_cnt_r + 5'd1;
          end
        end else begin
          s_cnt_nxt_s = s_cnt_r;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_cnt_r == 5'(SB_TICK - 1)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            s_cnt_nxt_s = s_cnt_r + 5'd1;
          end
        end else begin
          s_cnt_nxt_s = s_cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        s_cnt_nxt_s = 5'd0;
      end
    endcase
  end

  // Word completes on the final stop-bit tick.
  always_comb begin
    if ((state_r == ST_STOP) && s_tick && (s_cnt_r == 5'(SB_TICK - 1))) begin
      done_set_s = 1'b1;
    end else begin
      done_set_s = 1'b0;
    end
  end

  // Registered outputs; word and error flags hold until the next completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r       <= 1'b0;
      dout_r       <= '0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      done_r <= done_set_s;
      if (done_set_s) begin
        dout_r      <= b_shift_r;
        frame_err_r <= ~rx_sync_r;
`ifdef UART_RX_PARITY_EN
        parity_err_r <= even_parity_err(b_shift_r, par_bit_r);
`else
        parity_err_r <= 1'b0;
`endif
      end
    end
  end

  assign dout         = dout_r;
  assign rx_done_tick = done_r;
  assign frame_err    = frame_err_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected words, a monitor pops on rx_done_tick.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT_CLK = 256;  // 16 s_ticks x 16 clk

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  exp_t exp_q[$];
  int   n_tests_mon = 0, n_fail_mon = 0;
  int   n_tests_dir = 0, n_fail_dir = 0;
  logic prev_done = 1'b0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (15) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every strobe and checks the strobe is one clk wide.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && prev_done) begin
      n_tests_mon++;
      if (rx_done_tick) begin
        n_fail_mon++;
        $display("FAIL strobe_width: rx_done_tick=%0b required 0 one clk after strobe", rx_done_tick);
      end
    end
    prev_done = rx_done_tick;
    if (rx_done_tick) begin
      n_tests_mon++;
      if (exp_q.size() == 0) begin
        n_fail_mon++;
        $display("FAIL unexpected_strobe: dout=%02h frame_err=%0b with nothing expected", dout, frame_err);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e.d || frame_err !== e.fe
`ifdef UART_RX_PARITY_EN
            || parity_err !== e.pe
`endif
           ) begin
          n_fail_mon++;
`ifdef UART_RX_PARITY_EN
          $display("FAIL frame: dout=%02h fe=%0b pe=%0b required dout=%02h fe=%0b pe=%0b",
                   dout, frame_err, parity_err, e.d, e.fe, e.pe);
`else
          $display("FAIL frame: dout=%02h fe=%0b required dout=%02h fe=%0b", dout, frame_err, e.d, e.fe);
`endif
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    n_tests_dir++;
    if (got !== req) begin
      n_fail_dir++;
      $display("FAIL %s: got %02h required %02h", name, got, req);
    end
  endtask

  task automatic line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // good_stop=0 holds the stop bit low across its mid-point, then returns high before the bit ends.
  task automatic send_frame(input logic [7:0] d, input logic good_stop, input logic par);
    line(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) line(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    line(par, BIT_CLK);
`else
    if (par === 1'bx) $display("par unused");
`endif
    if (good_stop) line(1'b1, BIT_CLK);
    else begin
      line(1'b0, 192);
      line(1'b1, 64);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_done", {7'd0, rx_done_tick}, 8'h00);
    check("reset_ferr", {7'd0, frame_err}, 8'h00);
    reset_n = 1'b1;
    line(1'b1, 2 * BIT_CLK);

    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    line(1'b1, BIT_CLK);

    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    line(1'b1, BIT_CLK);

    line(1'b0, 4 * 16);
    line(1'b1, 2 * BIT_CLK);
    check("glitch_no_strobe_dout", dout, 8'hFF);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    line(1'b1, BIT_CLK);

    expect_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    line(1'b1, BIT_CLK);
    check("ferr_held", {7'd0, frame_err}, 8'h01);
    expect_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0);
    line(1'b1, BIT_CLK);

    line(1'b0, BIT_CLK);
    line(1'b1, BIT_CLK);
    line(1'b1, BIT_CLK);
    line(1'b0, BIT_CLK);
    line(1'b0, 100);
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (20) @(negedge clk);
    reset_n = 1'b1;
    line(1'b1, 2 * BIT_CLK);
    check("midreset_dout", dout, 8'h00);
    check("midreset_ferr", {7'd0, frame_err}, 8'h00);
    expect_frame(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    line(1'b1, BIT_CLK);

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    line(1'b1, BIT_CLK);
    expect_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    line(1'b1, BIT_CLK);
`endif

    line(1'b1, 2 * BIT_CLK);
    check("pending_frames", 8'(exp_q.size()), 8'h00);
    check("final_dout", dout, 8'h7E
`ifdef UART_RX_PARITY_EN
          ^ 8'h79
`endif
         );
    $display("[TB] %0d tests run, %0d failed", n_tests_mon + n_tests_dir, n_fail_mon + n_fail_dir);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART link; the receive-side counterpart of the existing transmitter, sharing the same 16x oversampling baud tick.
- Synchronises the asynchronous rx pin, detects and validates the start bit, samples each data bit LSB-first at its mid-point, and checks the stop bit.
- Presents each received word with a one-cycle done strobe and a framing-error flag.
- Sits between the board rx pin and the downstream FIFO/command logic.

Parameters:
- DBIT, 8, data bits per frame (5..8).
- SB_TICK, 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all flops rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_tick  input  1  oversampling enable, 16 pulses per bit period, one clk wide.
- rx  input  1  serial line, idle high; asynchronous to clk.
- dout  output  DBIT  last received word, LSB = first bit on the line.
- rx_done_tick  output  1  one-cycle strobe: dout/frame_err updated.
- frame_err  output  1  stop bit of the last frame sampled low.

Behaviour:
- Reset: every flop clears asynchronously while reset_n=0.
  - Synchroniser flops reset to 1; state=idle; counters=0; shift register=0.
  - Outputs: dout=0, rx_done_tick=0, frame_err=0.
- Synchroniser: 2-flop chain on rx; rx_s is the second flop. All FSM decisions use rx_s only, giving 2 clk of latency from the pin.
- Counters: s_reg is 5 bits (holds up to SB_TICK-1 = 31); n_reg is 3 bits; b_reg is DBIT bits. State advances only on cycles with s_tick=1, except idle→start.
- idle:
  - rx_s=0 → start, s_reg=0 (no s_tick needed).
- start:
  - On s_tick with s_reg==7 (mid start bit):
    - rx_s=0 → data, s_reg=0, n_reg=0.
    - rx_s=1 → false start (glitch); return to idle with no strobe and no output change.
  - Otherwise on s_tick, s_reg+1.
- data:
  - On s_tick with s_reg==15 (mid bit):
    - b_reg={rx_s, b_reg[DBIT-1:1]}; s_reg=0.
    - If n_reg==DBIT-1 → stop, else n_reg+1.
  - Otherwise on s_tick, s_reg+1.
- stop:
  - On s_tick with s_reg==SB_TICK-1: register dout=b_reg, frame_err=~rx_s, rx_done_tick=1 for the next clk cycle only, state=idle.
  - Otherwise on s_tick, s_reg+1.
- Output latency: rx_done_tick is high exactly one clk, in the cycle after the final stop-bit s_tick.
- Output holding: dout and frame_err hold until the next rx_done_tick.
- Framing error: the word is still delivered with frame_err=1. If rx_s stays low after the stop sample, idle re-enters start immediately; a break condition therefore yields repeated 0x00 frames, each with frame_err=1.
- Back-to-back frames: a start edge in the first clk after returning to idle must be accepted with no dead time beyond one clk.
- Concurrency: s_tick asserted in the same cycle as the idle→start transition is ignored, so counting begins on the next s_tick.
- Mid-frame reset: the frame is abandoned, no strobe is produced, and reception resumes at the next falling edge after reset_n deasserts.
- rx_done_tick never asserts for a rejected false start.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Extra state parity between data and stop, sampled on the mid-bit s_tick (s_reg==15).
  - Even parity: XOR of the received data bits and the parity bit must be 0.
  - Adds output parity_err (1 bit, reset 0), registered and updated together with rx_done_tick.
  - The word is delivered regardless of parity result.
- Undefined: the parity state and the parity_err port do not exist; the frame is start + DBIT + stop.

Test Plan:
- Clock 16 clk per s_tick (115200 baud × 16 at ~29.5 MHz scale); send 0xA5 with 1 stop bit → one rx_done_tick, dout=8'hA5, frame_err=0, strobe exactly 1 clk wide.
- Send 0x00, then 0xFF back-to-back with no idle gap → two strobes; dout=8'h00 then 8'hFF; frame_err=0 both times.
- Drive rx low for 4 s_ticks, then high (glitch) → no rx_done_tick; FSM back in idle; a following 0x3C frame is received correctly.
- Send 0x55 with the stop bit forced low → dout=8'h55, frame_err=1. The next valid 0x12 frame gives frame_err=0.
- Assert reset_n=0 mid-way through data bit 3 of 0xC3 → dout stays 0, no strobe. After release, 0x7E is received correctly.
- With UART_RX_PARITY_EN defined:
  - Send 0x07 with parity bit 1 → parity_err=0.
  - Send 0x07 with parity bit 0 → parity_err=1, dout=8'h07.
